// File: rtl/pipe_addsub_if.sv
// Handshake/data bundle for pipe_addsub: operand pair in, sum/diff pair out.
interface pipe_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [WIDTH-1:0] out_diff;
  logic [1:0]       out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_diff, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_diff, out_ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Two-stage valid/ready pipelined signed add/subtract (FFT butterfly helper).
// Define PIPE_ADDSUB_SAT_EN to clamp overflowed results instead of wrapping.
module pipe_addsub #(
  parameter int WIDTH = 8,
  parameter int SHIFT = 0
) (
  input  logic          CLK,
  input  logic          RST_N,
  pipe_addsub_if.slave  bus,
  output logic [15:0]   ovf_count
);

  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic             rdy_q;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d, diff_q, diff_d;
  logic [1:0]       ovf_q, ovf_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             s1_adv, s2_adv, in_xfer, out_xfer;
  logic [WIDTH:0]   sum_full, diff_full;
  logic [WIDTH-1:0] sum_res, diff_res;
  logic [1:0]       ovf_res;

  // rdy_q keeps in_ready low until the first edge after reset release
  assign s2_adv   = !s2_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = s2_valid_q && bus.out_ready;

  assign bus.in_ready  = rdy_q && s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_diff  = diff_q;
  assign bus.out_ovf   = ovf_q;
  assign ovf_count     = cnt_q;

  assign sum_full  = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
  assign diff_full = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};

  always_comb begin
    sum_res  = sum_full[WIDTH-1:0];
    diff_res = diff_full[WIDTH-1:0];
    ovf_res  = 2'b00;
    if (SHIFT == 1) begin
      // halving always fits, so no overflow is possible here
      sum_res  = sum_full[WIDTH:1];
      diff_res = diff_full[WIDTH:1];
    end else begin
      ovf_res[0] = sum_full[WIDTH] ^ sum_full[WIDTH-1];
      ovf_res[1] = diff_full[WIDTH] ^ diff_full[WIDTH-1];
`ifdef PIPE_ADDSUB_SAT_EN
      if (ovf_res[0]) sum_res  = sum_full[WIDTH]  ? MIN_V : MAX_V;
      if (ovf_res[1]) diff_res = diff_full[WIDTH] ? MIN_V : MAX_V;
`else
      sum_res  = sum_full[WIDTH-1:0];
      diff_res = diff_full[WIDTH-1:0];
`endif
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    diff_d     = diff_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    if (s1_adv) s1_valid_d = in_xfer;
    if (in_xfer) begin
      a_d = bus.in_a;
      b_d = bus.in_b;
    end
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s2_adv && s1_valid_q) begin
      sum_d  = sum_res;
      diff_d = diff_res;
      ovf_d  = ovf_res;
    end
    if (out_xfer && (ovf_q != 2'b00) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      diff_q     <= '0;
      ovf_q      <= 2'b00;
      cnt_q      <= 16'd0;
    end else begin
      rdy_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      diff_q     <= diff_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: SHIFT=0 and SHIFT=1 instances driven in lockstep,
// checked against an integer-arithmetic reference and an in-order queue.
module tb_pipe_addsub;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] ovf_count0, ovf_count1;

  pipe_addsub_if #(.WIDTH(8)) b0 ();
  pipe_addsub_if #(.WIDTH(8)) b1 ();

  pipe_addsub #(.WIDTH(8), .SHIFT(0)) dut0 (.CLK(CLK), .RST_N(RST_N), .bus(b0), .ovf_count(ovf_count0));
  pipe_addsub #(.WIDTH(8), .SHIFT(1)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(b1), .ovf_count(ovf_count1));

  always #5 CLK = ~CLK;

  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  logic [15:0] q[$];
  logic [15:0] cnt0 = 16'd0;
  bit          stall_q = 1'b0;
  logic [7:0]  held_sum, held_diff;
  logic [1:0]  held_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: plain integer arithmetic on the signed operand values
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input bit shift,
                                output logic [7:0] s, output logic [7:0] d, output logic [1:0] f);
    int sa, sb, rs, rd;
    sa = int'($signed(a));
    sb = int'($signed(b));
    rs = sa + sb;
    rd = sa - sb;
    f  = 2'b00;
    if (shift) begin
      s = 8'(rs >>> 1);
      d = 8'(rd >>> 1);
    end else begin
      f[0] = (rs > 127) || (rs < -128);
      f[1] = (rd > 127) || (rd < -128);
`ifdef PIPE_ADDSUB_SAT_EN
      s = (rs > 127) ? 8'h7F : (rs < -128) ? 8'h80 : 8'(rs);
      d = (rd > 127) ? 8'h7F : (rd < -128) ? 8'h80 : 8'(rd);
`else
      s = 8'(rs);
      d = 8'(rd);
`endif
    end
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic rdy);
    b0.in_valid = v; b0.in_a = a; b0.in_b = b; b0.out_ready = rdy;
    b1.in_valid = v; b1.in_a = a; b1.in_b = b; b1.out_ready = rdy;
  endtask

  task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b, input logic rdy,
                     output bit acc);
    logic [7:0]  es, ed;
    logic [1:0]  ef, ef0;
    logic [15:0] pr;
    drive(v, a, b, rdy);
    #3;
    chk("hs_in_ready", b1.in_ready, b0.in_ready);
    chk("hs_out_valid", b1.out_valid, b0.out_valid);
    chk("ovf_count0", ovf_count0, cnt0);
    chk("ovf_count1", ovf_count1, 16'd0);
    if (stall_q) begin
      chk("hold_sum", b0.out_sum, held_sum);
      chk("hold_diff", b0.out_diff, held_diff);
      chk("hold_ovf", b0.out_ovf, held_ovf);
    end
    if (b0.out_valid) begin
      if (q.size() == 0) chk("spurious_valid", b0.out_valid, 1'b0);
      else begin
        pr = q[0];
        model(pr[15:8], pr[7:0], 1'b0, es, ed, ef0);
        chk("sum0", b0.out_sum, es);
        chk("diff0", b0.out_diff, ed);
        chk("ovf0", b0.out_ovf, ef0);
        model(pr[15:8], pr[7:0], 1'b1, es, ed, ef);
        chk("sum1", b1.out_sum, es);
        chk("diff1", b1.out_diff, ed);
        chk("ovf1", b1.out_ovf, ef);
        if (rdy) begin
          void'(q.pop_front());
          if (ef0 != 2'b00 && cnt0 != 16'hFFFF) cnt0++;
        end
      end
    end
    acc = v && b0.in_ready;
    if (acc) q.push_back({a, b});
    stall_q   = b0.out_valid && !rdy;
    held_sum  = b0.out_sum;
    held_diff = b0.out_diff;
    held_ovf  = b0.out_ovf;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, b0.in_ready, 1'b0);
    chk({tag, "_out_valid"}, b0.out_valid, 1'b0);
    chk({tag, "_out_valid1"}, b1.out_valid, 1'b0);
    chk({tag, "_sum"}, b0.out_sum, 8'h00);
    chk({tag, "_diff"}, b0.out_diff, 8'h00);
    chk({tag, "_ovf"}, b0.out_ovf, 2'b00);
    chk({tag, "_cnt"}, ovf_count0, 16'd0);
  endtask

  task automatic drain(input string tag);
    bit acc;
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1'b0, 8'h00, 8'h00, 1'b1, acc);
    chk(tag, q.size(), 0);
  endtask

  initial begin
    bit acc, saw_stall;
    int idx, c;
    logic [7:0] pa[8];
    logic [7:0] pb[8];
    drive(1'b0, 8'h00, 8'h00, 1'b1);

    // power-on reset
    #12;
    chk_reset_state("por");
    @(posedge CLK); #3;
    RST_N = 1'b1;
    #1;
    chk("por_ready_before_edge", b0.in_ready, 1'b0);
    @(posedge CLK); #1;
    chk("por_ready_after_edge", b0.in_ready, 1'b1);

    // A=0x35 B=0x53: two cycles to out_valid
    cyc(1'b1, 8'h35, 8'h53, 1'b1, acc);
    chk("lat_accept", acc, 1'b1);
    chk("lat_not_yet", b0.out_valid, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, acc);
    chk("lat_valid", b0.out_valid, 1'b1);
`ifdef PIPE_ADDSUB_SAT_EN
    chk("v1_sum", b0.out_sum, 8'h7F);
`else
    chk("v1_sum", b0.out_sum, 8'h88);
`endif
    chk("v1_diff", b0.out_diff, 8'hE2);
    chk("v1_ovf", b0.out_ovf, 2'b01);
    chk("v1_sum_sh", b1.out_sum, 8'h44);
    chk("v1_diff_sh", b1.out_diff, 8'hF1);
    chk("v1_ovf_sh", b1.out_ovf, 2'b00);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, acc);
    chk("v1_count", ovf_count0, 16'd1);
    chk("v1_count_sh", ovf_count1, 16'd0);

    // A=0x80 B=0x01: difference overflows negative
    cyc(1'b1, 8'h80, 8'h01, 1'b1, acc);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, acc);
    chk("v2_sum", b0.out_sum, 8'h81);
`ifdef PIPE_ADDSUB_SAT_EN
    chk("v2_diff", b0.out_diff, 8'h80);
`else
    chk("v2_diff", b0.out_diff, 8'h7F);
`endif
    chk("v2_ovf", b0.out_ovf, 2'b10);
    drain("v2_drain");

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, 8'($urandom), 8'($urandom), ($urandom % 3) != 0, acc);
    drain("rand_drain");

    // 8 back-to-back pairs, downstream stalled in cycles 3..6
    for (int i = 0; i < 8; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    idx = 0; c = 1; saw_stall = 1'b0;
    while (idx < 8 && c < 60) begin
      if (!b0.in_ready) saw_stall = 1'b1;
      cyc(1'b1, pa[idx], pb[idx], !(c >= 3 && c <= 6), acc);
      if (acc) idx++;
      c++;
    end
    chk("b2b_all_accepted", idx, 8);
    chk("b2b_in_ready_low", saw_stall, 1'b1);
    drain("b2b_drain");

    // reset with two pairs in flight
    cyc(1'b1, 8'h7F, 8'h7F, 1'b0, acc);
    cyc(1'b1, 8'h81, 8'h7F, 1'b0, acc);
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_state("mid");
    q.delete();
    cnt0 = 16'd0;
    stall_q = 1'b0;
    @(posedge CLK); #3;
    RST_N = 1'b1;
    #1;
    chk("mid_ready_before_edge", b0.in_ready, 1'b0);
    @(posedge CLK); #1;
    chk("mid_ready_after_edge", b0.in_ready, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 8'h00, 1'b1, acc);

    // 65540 overflowing pairs: counter must stick at 0xFFFF
    drive(1'b1, 8'h7F, 8'h01, 1'b1);
    for (int i = 0; i < 65540; i++) begin
      @(posedge CLK); #1;
    end
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
    end
    chk("sat_count", ovf_count0, 16'hFFFF);
    chk("sat_count_sh", ovf_count1, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
